// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: turns SUB flags plus branch metadata into a registered
// taken/target/mispredict result behind a valid/ready handshake. Optional macro: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic [2:0]      funct3,
  input  logic            flag_C,
  input  logic            flag_V,
  input  logic            flag_Z,
  input  logic            flag_N,
  input  logic [size-1:0] pc,
  input  logic [size-1:0] target_in,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [size-1:0] target,
  output logic            mispredict,
  output logic            illegal
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
`endif
);

  // state | meaning
  // EMPTY | no result held, outputs not valid
  // FULL  | result held on the registered outputs until out_ready or flush
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic            capture;
  logic            res_taken;
  logic            res_illegal;
  logic [size-1:0] res_target;
  logic [size-1:0] pc_plus4;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign pc_plus4  = pc + size'(4);

  always_comb begin
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    if (is_jump) begin
      res_taken = 1'b1;
    end else if (is_branch) begin
      case (funct3)
        3'b000:  res_taken = flag_Z;
        3'b001:  res_taken = !flag_Z;
        3'b100:  res_taken = flag_N ^ flag_V;
        3'b101:  res_taken = !(flag_N ^ flag_V);
        3'b110:  res_taken = !flag_C;
        3'b111:  res_taken = flag_C;
        default: res_illegal = 1'b1;
      endcase
    end
    res_target = res_taken ? target_in : pc_plus4;
  end

  always_comb begin
    state_nxt = state;
    if (flush)
      state_nxt = EMPTY;
    else if (capture)
      state_nxt = FULL;
    else if (state == FULL && out_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken      <= 1'b0;
      target     <= '0;
      mispredict <= 1'b0;
      illegal    <= 1'b0;
    end else if (capture) begin
      taken      <= res_taken;
      target     <= res_target;
      mispredict <= res_taken ^ pred_taken;
      illegal    <= res_illegal;
    end
  end

`ifdef BRU_PERF_CNT_EN
  // Counts consumed results only; flush does not clear them.
  logic handshake;
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (handshake) begin
      if (branch_count != 32'hFFFF_FFFF)
        branch_count <= branch_count + 32'd1;
      if (mispredict && mispredict_count != 32'hFFFF_FFFF)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer of the ALU's condition flags: takes C/V/Z/N from a SUB of rs1−rs2, together with branch metadata, and resolves RISC-V conditional branches and jumps.
- Single registered stage between execute and the fetch redirect path, with a valid/ready handshake.
- Outputs the taken decision, the branch target and mispredict/redirect information for the front end.

Parameters:
- size, 32, datapath/PC width in bits; must match the ALU's size.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of any held and incoming result.
- in_valid  input  1  a branch/jump op is presented.
- in_ready  output  1  the unit can accept the op this cycle.
- is_branch  input  1  conditional branch (uses funct3 and flags).
- is_jump  input  1  unconditional jump (JAL/JALR); takes priority over is_branch.
- funct3  input  3  branch condition code.
- flag_C, flag_V, flag_Z, flag_N  input  1 each  ALU flags of A−B; C=1 means no borrow.
- pc  input  size  PC of the op.
- target_in  input  size  precomputed target (pc+imm, or rs1+imm for JALR).
- pred_taken  input  1  front-end prediction.
- out_valid  output  1  result held.
- out_ready  input  1  the consumer accepts the result.
- taken  output  1  resolved direction.
- target  output  size  resolved next PC: target_in if taken, else pc+4.
- mispredict  output  1  taken ≠ pred_taken.
- illegal  output  1  is_branch with funct3 = 010 or 011.

Behaviour:
- Reset: out_valid, taken, mispredict and illegal are 0; target is 0. in_ready is 1 from the first cycle after reset.
- Handshake: in_ready = !out_valid || out_ready, computed combinationally.
  - Capture when in_valid && in_ready. The result appears on the registered outputs one cycle later (latency 1).
  - Full throughput when out_ready is held at 1.
- Output hold: while out_valid && !out_ready, all outputs stay stable. An input presented then is not captured (in_ready = 0).
- Conditions, evaluated at capture:
  - 000 BEQ = Z
  - 001 BNE = !Z
  - 100 BLT = N^V
  - 101 BGE = !(N^V)
  - 110 BLTU = !C
  - 111 BGEU = C
  - 010/011: taken = 0, illegal = 1.
- Jumps: is_jump forces taken = 1 and illegal = 0; funct3 and flags are ignored.
- No operation type: in_valid with neither is_branch nor is_jump gives taken = 0, illegal = 0, target = pc+4.
- Arithmetic: pc+4 wraps modulo 2^size (pc = 0xFFFFFFFC gives 0x00000000).
- Mispredict: mispredict = taken ^ pred_taken. The illegal case resolves as not taken.
- flush:
  - Next cycle out_valid = 0, and any in_valid in the flush cycle is dropped.
  - flush has priority over capture and over hold.
  - in_ready is 1 in the cycle after a flush.
- Simultaneous events:
  - A new capture while out_valid && out_ready replaces the result back-to-back.
  - reset has priority over flush.
  - reset mid-hold discards the held result.
- State: two states, EMPTY and FULL.
  - EMPTY→FULL on capture.
  - FULL→FULL on capture with out_ready.
  - FULL→EMPTY on out_ready without capture, or on flush.

Optional Feature:
- BRU_PERF_CNT_EN
- Defined: adds outputs branch_count and mispredict_count, each 32 bits.
  - Counters increment on each output handshake (out_valid && out_ready), counting results actually consumed; mispredict_count counts those with mispredict = 1.
  - Both reset to 0, saturate at 0xFFFFFFFF, and are not cleared by flush.
- Not defined: the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- BEQ, Z=1, pc=0x100, target_in=0x140, pred_taken=0 → next cycle out_valid=1, taken=1, target=0x140, mispredict=1.
- BLTU with C=1, pc=0x200, pred_taken=0 → taken=0, target=0x204, mispredict=0. Then BLT with N=1, V=0 → taken=1.
- Hold: result valid with out_ready=0 for 3 cycles while a new op is presented → outputs stable, in_ready=0. Release with out_ready=1 → new op captured that cycle, its result on the next cycle.
- flush asserted together with in_valid while FULL → next cycle out_valid=0, in_ready=1, and the dropped op never appears.
- Edge cases:
  - funct3=010 with is_branch → illegal=1, taken=0.
  - JAL at pc=0xFFFFFFFC, target_in=0x10 → taken=1, target=0x10.
  - Not-taken BNE (Z=1) at pc=0xFFFFFFFC → target=0x0.
- With BRU_PERF_CNT_EN: 10 back-to-back branches, 3 mispredicted, out_ready=1 → branch_count=10, mispredict_count=3. After reset → both 0.
